// File: rtl/q_flop_pipe_pkg.sv
// ============================================================================
// Module : q_pipe_pkg
// Brief  : Shared types and helpers for the Q-flop pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package q_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        SETTLING = 2'd1,
        READY    = 2'd2
    } q_state_e;

    // Settle counter width; never narrower than one bit.
    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/q_flop_pipe_stage.sv
// ============================================================================
// Module : q_stage
// Brief  : One Q-flop stage: data word plus valid bit, loaded on a Q-clock tick.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             v,
    output logic [WIDTH-1:0] q,
    output logic             qv
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // clear only drops the valid bit; the word itself is left in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (shift) begin
                r_data <= d;
            end
            if (clear) begin
                r_valid <= 1'b0;
            end else if (shift) begin
                r_valid <= v;
            end
        end
    end

    assign q  = r_data;
    assign qv = r_valid;

endmodule

`default_nettype wire

// File: rtl/q_flop_pipe.sv
// ============================================================================
// Module : q_flop_pipe
// Brief  : DEPTH-stage Q-flop pipeline with Q-clock controller and handshakes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_flop_pipe
    import q_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       ack_all,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int                 c_CNT_W      = cnt_width(SETTLE);
    localparam int                 c_OCC_W      = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LD  = c_CNT_W'(SETTLE);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam bit                 c_HAS_SETTLE = (SETTLE > 0);

    q_state_e           r_state;
    q_state_e           w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic [DEPTH-1:0]   w_valid;
    logic [WIDTH-1:0]   w_data [DEPTH];
    logic [DEPTH-1:0]   w_clear;
    logic [WIDTH-1:0]   w_head_d;

    logic w_tail_free;
    logic w_body_busy;
    logic w_out_valid;
    logic w_adv;
    logic w_in_ready;
    logic w_xfer_tail;

    assign w_tail_free = !w_valid[DEPTH-1] || out_ready;
    assign w_body_busy = |w_valid[DEPTH-2:0];
    assign w_out_valid = w_valid[DEPTH-1] && (r_state == READY);
    assign w_head_d    = in_valid ? in_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_adv       = 1'b0;
        w_in_ready  = 1'b0;
        w_xfer_tail = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    w_in_ready = 1'b1;
                    w_adv      = in_valid;
                end
                READY: begin
                    w_in_ready = w_tail_free;
                    w_adv      = w_tail_free && (in_valid || w_body_busy);
                end
                SETTLING: begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                    if (r_cnt <= c_CNT_ONE) begin
                        w_state_nxt = READY;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase

            // An advance always leaves at least one valid stage behind it.
            w_xfer_tail = w_out_valid && out_ready && !w_adv;
            if (w_adv) begin
                if (c_HAS_SETTLE) begin
                    w_state_nxt = SETTLING;
                    w_cnt_nxt   = c_SETTLE_LD;
                end else begin
                    w_state_nxt = READY;
                end
            end else if (w_xfer_tail) begin
                w_state_nxt = w_body_busy ? READY : EMPTY;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign w_clear[i] = flush || ((i == DEPTH - 1) && w_xfer_tail);
        if (i == 0) begin : g_head
            q_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .shift (w_adv),
                .clear (w_clear[i]),
                .d     (w_head_d),
                .v     (in_valid),
                .q     (w_data[i]),
                .qv    (w_valid[i])
            );
        end else begin : g_body
            q_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .shift (w_adv),
                .clear (w_clear[i]),
                .d     (w_data[i-1]),
                .v     (w_valid[i-1]),
                .q     (w_data[i]),
                .qv    (w_valid[i])
            );
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_data[DEPTH-1];
    assign ack_all   = (r_state != SETTLING);
    assign occupancy = c_OCC_W'(popcount(32'(w_valid)));

endmodule

`default_nettype wire

// File: tb/tb_q_flop_pipe.sv
// ============================================================================
// Module : tb_q_flop_pipe
// Brief  : Self-checking bench for q_flop_pipe (SETTLE=2 and SETTLE=0 builds).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_q_flop_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush, in_valid, out_ready, in_ready, out_valid, ack_all;
    logic [7:0] in_data, out_data;
    logic [2:0] occupancy;

    logic       z_flush, z_in_valid, z_out_ready, z_in_ready, z_out_valid, z_ack_all;
    logic [7:0] z_in_data, z_out_data;
    logic [2:0] z_occupancy;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    q_flop_pipe #(.WIDTH(8), .DEPTH(4), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .ack_all(ack_all), .occupancy(occupancy)
    );

    q_flop_pipe #(.WIDTH(8), .DEPTH(4), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .flush(z_flush), .in_data(z_in_data), .in_valid(z_in_valid),
        .in_ready(z_in_ready), .out_data(z_out_data), .out_valid(z_out_valid),
        .out_ready(z_out_ready), .ack_all(z_ack_all), .occupancy(z_occupancy)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_occ;
        logic       e_ack;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy, logic ir,
                                logic ov, logic [7:0] od, logic [2:0] occ, logic ack);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.e_ir = ir;
        v.e_ov = ov; v.e_od = od; v.e_occ = occ; v.e_ack = ack;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: words accepted at the input must leave in the same order.
    task automatic observe(input string tag);
        if (in_valid && in_ready) sb.push_back(in_data);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk({tag, " unexpected output"}, 32'd1, 32'd0);
            else                chk({tag, " data"}, 32'(out_data), 32'(sb.pop_front()));
        end
    endtask

    task automatic drain(input string tag, input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            observe(tag);
            if (occupancy == 3'd0 && sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk({tag, " drained words left"}, 32'(sb.size()), 32'd0);
        chk({tag, " drained occupancy"}, 32'(occupancy), 32'd0);
        chk({tag, " drained in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vec_t tbl[14];
        int   cyc, first_cap, last_cap, lat, seen, sent, outs;
        logic cap, found, prev_hold;
        logic [7:0] prev_data;
        logic [7:0] zq_d[$];
        int         zq_c[$];

        // single word A5, SETTLE=2: settles 2 cycles per stage, out at cycle 12
        tbl[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1);
        tbl[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 1'b1);
        tbl[4]  = tbl[1];
        tbl[5]  = tbl[1];
        tbl[6]  = tbl[3];
        tbl[7]  = tbl[1];
        tbl[8]  = tbl[1];
        tbl[9]  = tbl[3];
        tbl[10] = tbl[1];
        tbl[11] = tbl[1];
        tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b1);
        tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1);

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = 8'h00; z_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset ack_all", 32'(ack_all), 32'd1);
        chk("reset occupancy", 32'(occupancy), 32'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // ---- single word, table driven ----
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("single[%0d] in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("single[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("single[%0d] occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("single[%0d] ack_all", i), 32'(ack_all), 32'(tbl[i].e_ack));
            if (tbl[i].e_ov) chk($sformatf("single[%0d] out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            @(posedge clk); #1;
        end

        // ---- streaming 1,2,3... ----
        sb.delete();
        in_valid = 1'b1; in_data = 8'd1; out_ready = 1'b1;
        first_cap = -1; last_cap = -1; outs = 0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            cap = in_valid && in_ready;
            if (cap) begin
                if (last_cap >= 0) chk("stream capture gap", 32'(cyc - last_cap), 32'd3);
                else first_cap = cyc;
                last_cap = cyc;
            end
            if (out_valid && out_ready) begin
                if (outs == 0) chk("stream first latency", 32'(cyc - first_cap), 32'd12);
                outs++;
            end
            observe("stream");
            @(posedge clk); #1;
            if (cap) in_data = in_data + 8'd1;
        end
        chk("stream output count", 32'(outs), 32'd16);
        drain("stream", 40);

        // ---- backpressure ----
        sb.delete();
        in_valid = 1'b1; in_data = 8'h40; out_ready = 1'b0; found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cap = in_valid && in_ready;
            observe("bp");
            if (occupancy == 3'd4 && ack_all) begin found = 1'b1; break; end
            @(posedge clk); #1;
            if (cap) in_data = in_data + 8'd1;
        end
        chk("bp reached full", 32'(found), 32'd1);
        chk("bp full in_ready", 32'(in_ready), 32'd0);
        chk("bp full out_valid", 32'(out_valid), 32'd1);
        chk("bp full out_data", 32'(out_data), 32'h40);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_data = in_data + 8'd1;
            @(negedge clk);
            chk("bp hold out_data", 32'(out_data), 32'h40);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
            chk("bp hold occupancy", 32'(occupancy), 32'd4);
        end
        @(posedge clk); #1;
        drain("bp", 40);

        // ---- flush during SETTLING with 3 words ----
        sb.delete();
        in_valid = 1'b1; in_data = 8'h80; out_ready = 1'b0; found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cap = in_valid && in_ready;
            if (occupancy == 3'd3 && !ack_all) begin found = 1'b1; break; end
            @(posedge clk); #1;
            if (cap) in_data = in_data + 8'd1;
        end
        chk("flush reached 3 settling", 32'(found), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush occupancy", 32'(occupancy), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready after", 32'(in_ready), 32'd1);
        chk("flush ack_all", 32'(ack_all), 32'd1);
        // flush outranks a capture offered while EMPTY
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        @(negedge clk);
        chk("flush vs capture in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush vs capture occupancy", 32'(occupancy), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        @(negedge clk);
        chk("relaunch in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; lat = 1; found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                chk("relaunch latency", 32'(lat), 32'd12);
                chk("relaunch data", 32'(out_data), 32'h5A);
                break;
            end
            lat++;
            @(posedge clk); #1;
        end
        chk("relaunch output seen", 32'(found), 32'd1);
        @(posedge clk); #1;

        // ---- asynchronous reset mid-SETTLING ----
        in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_data", 32'(out_data), 32'd0);
        chk("async rst ack_all", 32'(ack_all), 32'd1);
        chk("async rst occupancy", 32'(occupancy), 32'd0);
        #1 rst = 1'b1;
        out_ready = 1'b1; seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid || occupancy != 3'd0) seen++;
        end
        chk("post-reset idle", 32'(seen), 32'd0);
        @(posedge clk); #1;

        // ---- SETTLE=0 streaming on second instance ----
        sent = 0; outs = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            z_in_valid = (sent < 8);
            z_in_data  = 8'hC0 + 8'(sent);
            @(negedge clk);
            chk("s0 ack_all", 32'(z_ack_all), 32'd1);
            if (z_in_valid) begin
                chk("s0 in_ready", 32'(z_in_ready), 32'd1);
                if (z_in_ready) begin
                    zq_d.push_back(z_in_data);
                    zq_c.push_back(cyc);
                    sent++;
                end
            end
            if (z_out_valid && z_out_ready) begin
                if (zq_d.size() == 0) chk("s0 unexpected output", 32'd1, 32'd0);
                else begin
                    chk("s0 data", 32'(z_out_data), 32'(zq_d.pop_front()));
                    chk("s0 latency", 32'(cyc - zq_c.pop_front()), 32'd4);
                    outs++;
                end
            end
            @(posedge clk); #1;
        end
        z_in_valid = 1'b0;
        chk("s0 output count", 32'(outs), 32'd8);

        // ---- randomized run against scoreboard ----
        sb.delete();
        prev_hold = 1'b0; prev_data = 8'h00;
        for (int k = 0; k < 600; k++) begin
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rand occupancy", 32'(occupancy), 32'(sb.size()));
            if (flush) chk("rand flush in_ready", 32'(in_ready), 32'd0);
            if (out_valid) chk("rand ack with out_valid", 32'(ack_all), 32'd1);
            if (prev_hold) begin
                chk("rand hold out_valid", 32'(out_valid), 32'd1);
                chk("rand hold out_data", 32'(out_data), 32'(prev_data));
            end
            observe("rand");
            if (flush) sb.delete();
            prev_hold = out_valid && !out_ready && !flush;
            prev_data = out_data;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        drain("rand", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
